wave_capture: RTL and testbench
===============================

# wave_capture

Captures a triggered window of audio samples for waveform display, sitting directly downstream of `music_player` on its `sample_out` / `new_sample_generated` outputs. On a positive-going zero crossing it writes 2^ADDR_WIDTH consecutive samples, reduced to 8-bit offset binary, into one half of a ping-pong display RAM. It then waits for the display engine to report idle, and swaps halves so the display always reads a complete, stable frame.

## Interface
- `ADDR_WIDTH`, default 8: log2 of samples per frame; frame length is 256 at default.
- `TIMEOUT_SAMPLES`, default 4800: forced-trigger limit in samples; used only with `WAVE_CAPTURE_TIMEOUT_EN`.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `new_sample_ready` in 1: one-cycle strobe marking a valid `new_sample_in`; driven from `music_player.new_sample_generated`.
- `new_sample_in` in 16: signed two's-complement sample; driven from `music_player.sample_out`.
- `wave_display_idle` in 1: level from the display; high means the display is not reading the RAM.
- `write_address` out ADDR_WIDTH+1: RAM write address, `{~read_index, sample_count}`.
- `write_enable` out 1: one-cycle RAM write strobe.
- `write_sample` out 8: `{~new_sample_in[15], new_sample_in[14:8]}`, i.e. offset binary.
- `read_index` out 1: which RAM half the display reads; the writer always uses the other half.
- `frame_done` out 1: one-cycle pulse when the last sample of a frame is written.

## Operation
- `prev_sample[15:0]` register:
  - Loads `new_sample_in` on every `new_sample_ready` strobe, in every state.
  - Reset value is 0.
- ARMED:
  - Trigger condition: `new_sample_ready` && `prev_sample[15]`==1 && `new_sample_in[15]`==0.
  - On trigger: write the triggering sample at index 0, set `sample_count` to 1, go to ACTIVE.
- ACTIVE:
  - Each strobe writes at index `sample_count`, then increments `sample_count`.
  - On writing index 2^ADDR_WIDTH-1: pulse `frame_done`, clear `sample_count` to 0 (wraps), go to WAIT.
- WAIT:
  - Strobes produce no writes.
  - When `wave_display_idle`==1: toggle `read_index`, go to ARMED.
- Trigger rules:
  - An exact 0x0000 following a negative sample counts as a crossing.
  - 0x0000 following 0x0000 does not.
  - The first sample after reset never triggers, because `prev_sample` resets to 0.
- `wave_display_idle` is ignored in ARMED and ACTIVE.
- A strobe arriving in the same cycle WAIT exits is not written and cannot trigger. Its value is still loaded into `prev_sample`.

## Timing
- Reset state: ARMED, `sample_count`=0, `read_index`=0.
- Reset values of outputs: `write_enable`=0, `write_address`=0, `write_sample`=0, `frame_done`=0.
- Write latency: `write_enable`, `write_address` and `write_sample` are registered and assert exactly 1 cycle after the accepted strobe. They hold until the next write.
- `frame_done` asserts in the same cycle as the final `write_enable`.
- `read_index` toggles 1 cycle after `wave_display_idle` is sampled high in WAIT.
- Back-to-back strobes on consecutive cycles must each be handled. The codec limits them to 48 kHz, but the RTL must not rely on that.
- `reset_n` deasserting mid-frame:
  - Returns to ARMED with `read_index`=0.
  - The partially written half is simply overwritten by the next frame.

## Configuration
- `WAVE_CAPTURE_TIMEOUT_EN` defined:
  - An armed-sample counter increments on each strobe in ARMED and clears on leaving ARMED.
  - If a strobe arrives with the counter equal to TIMEOUT_SAMPLES-1, that strobe force-triggers like a crossing.
  - Gives a free-running display for silence or DC input.
- Not defined: no counter is built, and ARMED waits indefinitely for a crossing.

## Test plan
- Reset, strobe 0x8000, then 0x0100 -> `write_enable` 1 cycle after the second strobe, `write_address`=0x100 (`read_index`=0), `write_sample`=0x81.
- Sine with 256 strobes after trigger -> 256 writes at addresses 0x100–0x1FF, `frame_done` with the 0x1FF write, state WAIT, further strobes give no `write_enable`.
- In WAIT, hold `wave_display_idle`=0 for 1000 strobes, then raise it -> no writes until `read_index`=1, next frame writes to 0x000–0x0FF.
- Samples 0x0000, 0x0000, 0x7FFF -> no trigger. Samples 0xFFFF, 0x0000 -> trigger, index 0 `write_sample`=0x80.
- Assert `reset_n`=0 after 100 frame writes -> all outputs 0 asynchronously, a new crossing restarts at index 0 of half 0x100.
- With `WAVE_CAPTURE_TIMEOUT_EN`, TIMEOUT_SAMPLES=10, constant 0x1234 input -> write at 0x100 on the 10th strobe. Without the macro -> no write ever.

Source files
------------

// File: rtl/wave_capture.sv
// ============================================================================
// wave_capture
// ----------------------------------------------------------------------------
// Captures a triggered window of audio samples into a ping-pong display RAM.
// The block arms on a positive-going zero crossing. It then writes
// 2^ADDR_WIDTH consecutive samples, reduced to 8-bit offset binary, into the
// RAM half the display is not reading. After that it waits for the display to
// go idle and swaps halves, so the display always reads a complete, stable
// frame.
//
// Optional feature macro:
//   WAVE_CAPTURE_TIMEOUT_EN - builds an armed-sample counter. After
//                             TIMEOUT_SAMPLES strobes without a crossing, the
//                             block force-triggers, so silence or DC input
//                             still gives a free-running display.
//
// Parameters:
//   ADDR_WIDTH       log2 of samples per frame (default 8 -> 256 samples)
//   TIMEOUT_SAMPLES  forced-trigger limit in samples (timeout build only)
//
// Ports:
//   clk                in   system clock
//   reset_n            in   asynchronous active-low reset
//   new_sample_ready   in   one-cycle strobe qualifying new_sample_in
//   new_sample_in      in   16-bit signed two's-complement sample
//   wave_display_idle  in   high while the display is not reading the RAM
//   write_address      out  RAM write address {~read_index, sample index}
//   write_enable       out  one-cycle RAM write strobe
//   write_sample       out  8-bit offset-binary sample for the RAM
//   read_index         out  RAM half the display reads
//   frame_done         out  one-cycle pulse together with the last write
// ============================================================================
module wave_capture #(
    parameter int ADDR_WIDTH      = 8,
    parameter int TIMEOUT_SAMPLES = 4800
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  new_sample_ready,
    input  logic [15:0]           new_sample_in,
    input  logic                  wave_display_idle,
    output logic [ADDR_WIDTH:0]   write_address,
    output logic                  write_enable,
    output logic [7:0]            write_sample,
    output logic                  read_index,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        ST_ARMED,
        ST_ACTIVE,
        ST_WAIT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] sample_count;
    logic [ADDR_WIDTH-1:0] count_next;
    logic [ADDR_WIDTH-1:0] wr_index;
    logic [15:0]           prev_sample;
    logic                  read_index_next;
    logic                  wr_go;
    logic                  wr_last;
    logic                  crossing;
    logic                  force_trigger;

    // Negative previous sample followed by a non-negative one. An exact
    // 0x0000 after a negative sample counts; 0x0000 after 0x0000 does not.
    assign crossing = prev_sample[15] & ~new_sample_in[15];

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_SAMPLES > 1) ? $clog2(TIMEOUT_SAMPLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_SAMPLES - 1);

    logic [TW-1:0] armed_count;

    // Counts strobes seen while armed. The strobe that finds the counter at
    // its last value triggers, so the counter never has to pass it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_count <= '0;
        end else if (state != ST_ARMED || state_next != ST_ARMED) begin
            armed_count <= '0;
        end else if (new_sample_ready) begin
            armed_count <= armed_count + TW'(1);
        end
    end

    assign force_trigger = (armed_count == TIMEOUT_LAST);
`else
    assign force_trigger = 1'b0;
`endif

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next      = state;
        count_next      = sample_count;
        read_index_next = read_index;
        wr_go           = 1'b0;
        wr_last         = 1'b0;
        wr_index        = sample_count;

        case (state)
            ST_ARMED: begin
                if (new_sample_ready && (crossing || force_trigger)) begin
                    wr_go      = 1'b1;
                    wr_index   = '0;
                    count_next = ADDR_WIDTH'(1);
                    state_next = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    wr_go = 1'b1;
                    if (sample_count == LAST_INDEX) begin
                        wr_last    = 1'b1;
                        count_next = '0;
                        state_next = ST_WAIT;
                    end else begin
                        count_next = sample_count + ADDR_WIDTH'(1);
                    end
                end
            end

            ST_WAIT: begin
                // A strobe arriving while the block leaves this state is
                // dropped. It still updates prev_sample below.
                if (wave_display_idle) begin
                    read_index_next = ~read_index;
                    state_next      = ST_ARMED;
                end
            end

            default: begin
                state_next = ST_ARMED;
                count_next = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // sees the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_ARMED;
            sample_count <= '0;
            read_index   <= 1'b0;
            prev_sample  <= '0;
        end else begin
            state        <= state_next;
            sample_count <= count_next;
            read_index   <= read_index_next;
            if (new_sample_ready) begin
                prev_sample <= new_sample_in;
            end
        end
    end

    // Registered RAM write port. The address and data hold between writes,
    // and the enable and frame_done signals are single-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_enable  <= 1'b0;
            frame_done    <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
        end else begin
            write_enable <= wr_go;
            frame_done   <= wr_last;
            if (wr_go) begin
                write_address <= {~read_index, wr_index};
                write_sample  <= {~new_sample_in[15], new_sample_in[14:8]};
            end
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
// ============================================================================
// tb_wave_capture
// ----------------------------------------------------------------------------
// Directed testbench for wave_capture (ADDR_WIDTH=8, TIMEOUT_SAMPLES=10).
// Strobes are driven on the falling edge and can be back-to-back. Each
// strobe's registered result is sampled on the following falling edge.
// ============================================================================
module tb_wave_capture;

    logic        clk;
    logic        reset_n;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] sine [16] = '{
        16'h0000, 16'h30FB, 16'h5A82, 16'h7641, 16'h7FFF, 16'h7641, 16'h5A82, 16'h30FB,
        16'h0000, 16'hCF05, 16'hA57E, 16'h89BF, 16'h8001, 16'h89BF, 16'hA57E, 16'hCF05
    };

    wave_capture #(
        .ADDR_WIDTH      (8),
        .TIMEOUT_SAMPLES (10)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index),
        .frame_done        (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] offset8(input logic [15:0] s);
        return {~s[15], s[14:8]};
    endfunction

    // One strobe; returns the outputs registered from it.
    task automatic strobe(input logic [15:0] s, output logic we, output logic [8:0] addr,
                          output logic [7:0] ws, output logic fd);
        new_sample_ready = 1'b1;
        new_sample_in    = s;
        @(negedge clk);
        we   = write_enable;
        addr = write_address;
        ws   = write_sample;
        fd   = frame_done;
        new_sample_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Trigger with 0x8000, 0x0100, then 255 sine strobes; checks every write.
    task automatic run_frame(input logic [8:0] base, input string tag);
        logic we, fd;
        logic [8:0] a;
        logic [7:0] ws;
        int bad;
        strobe(16'h8000, we, a, ws, fd);
        strobe(16'h0100, we, a, ws, fd);
        checks++;
        if (we !== 1'b1 || a !== base || ws !== 8'h81 || fd !== 1'b0) begin
            errors++;
            $display("FAIL %s_first: we=%b addr=%h ws=%h fd=%b, expected we=1 addr=%h ws=81 fd=0",
                     tag, we, a, ws, fd, base);
        end
        bad = 0;
        for (int i = 1; i < 256; i++) begin
            strobe(sine[i % 16], we, a, ws, fd);
            checks++;
            if (we !== 1'b1 || a !== base + 9'(i) || ws !== offset8(sine[i % 16])
                || fd !== (i == 255)) begin
                errors++;
                if (bad < 5)
                    $display("FAIL %s_idx%0d: we=%b addr=%h ws=%h fd=%b, expected we=1 addr=%h ws=%h fd=%b",
                             tag, i, we, a, ws, fd, base + 9'(i), offset8(sine[i % 16]), i == 255);
                bad++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (write_enable !== 1'b0 || write_address !== 9'h000 || write_sample !== 8'h00
            || frame_done !== 1'b0 || read_index !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: we=%b addr=%h ws=%h fd=%b ri=%b, expected all 0",
                     write_enable, write_address, write_sample, frame_done, read_index);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_trigger();
        logic we, fd;
        logic [8:0] a;
        logic [7:0] ws;
        strobe(16'h8000, we, a, ws, fd);
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL no_trigger_8000: we=%b, expected 0", we);
        end
        strobe(16'h0100, we, a, ws, fd);
        checks++;
        if (we !== 1'b1 || a !== 9'h100 || ws !== 8'h81) begin
            errors++;
            $display("FAIL first_write: we=%b addr=%h ws=%h, expected we=1 addr=100 ws=81", we, a, ws);
        end
        // A gap cycle: the enable drops while the address and data hold.
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b0 || write_address !== 9'h100 || write_sample !== 8'h81) begin
            errors++;
            $display("FAIL write_hold: we=%b addr=%h ws=%h, expected we=0 addr=100 ws=81",
                     write_enable, write_address, write_sample);
        end
    endtask

    // Indices 1..255 back-to-back, then strobes in WAIT produce nothing.
    task automatic test_back_to_back();
        logic we, fd;
        logic [8:0] a;
        logic [7:0] ws;
        int bad = 0;
        for (int i = 1; i < 256; i++) begin
            strobe(sine[i % 16], we, a, ws, fd);
            checks++;
            if (we !== 1'b1 || a !== 9'h100 + 9'(i) || ws !== offset8(sine[i % 16])
                || fd !== (i == 255)) begin
                errors++;
                if (bad < 5)
                    $display("FAIL frame1_idx%0d: we=%b addr=%h ws=%h fd=%b", i, we, a, ws, fd);
                bad++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            strobe(16'h8000, we, a, ws, fd);
            strobe(16'h0100, we, a, ws, fd);
            checks++;
            if (we !== 1'b0 || fd !== 1'b0) begin
                errors++;
                $display("FAIL wait_no_write%0d: we=%b fd=%b, expected 0 0", i, we, fd);
            end
        end
    endtask

    task automatic test_wait_hold();
        logic we, fd;
        logic [8:0] a;
        logic [7:0] ws;
        int writes = 0;
        for (int i = 0; i < 1000; i++) begin
            strobe(sine[i % 16], we, a, ws, fd);
            if (we) writes++;
        end
        checks++;
        if (writes !== 0 || read_index !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold: writes=%0d ri=%b, expected 0 writes ri=0", writes, read_index);
        end
        wave_display_idle = 1'b1;
        @(negedge clk);
        wave_display_idle = 1'b0;
        checks++;
        if (read_index !== 1'b1) begin
            errors++;
            $display("FAIL swap_to_1: ri=%b, expected 1", read_index);
        end
        run_frame(9'h000, "frame2");
    endtask

    task automatic test_wait_exit_strobe();
        logic we, fd;
        logic [8:0] a;
        logic [7:0] ws;
        strobe(16'hFFFF, we, a, ws, fd);
        // Would be a crossing, but it lands in the cycle WAIT exits.
        wave_display_idle = 1'b1;
        strobe(16'h0000, we, a, ws, fd);
        wave_display_idle = 1'b0;
        checks++;
        if (we !== 1'b0 || read_index !== 1'b0) begin
            errors++;
            $display("FAIL exit_strobe: we=%b ri=%b, expected we=0 ri=0", we, read_index);
        end
        strobe(16'h0000, we, a, ws, fd);
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL zero_after_zero: we=%b, expected 0", we);
        end
        strobe(16'h7FFF, we, a, ws, fd);
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL positive_after_zero: we=%b, expected 0", we);
        end
    endtask

    task automatic test_zero_crossing();
        logic we, fd;
        logic [8:0] a;
        logic [7:0] ws;
        strobe(16'hFFFF, we, a, ws, fd);
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL negative_no_trigger: we=%b, expected 0", we);
        end
        strobe(16'h0000, we, a, ws, fd);
        checks++;
        if (we !== 1'b1 || a !== 9'h100 || ws !== 8'h80) begin
            errors++;
            $display("FAIL exact_zero_trigger: we=%b addr=%h ws=%h, expected we=1 addr=100 ws=80", we, a, ws);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic we, fd;
        logic [8:0] a;
        logic [7:0] ws;
        for (int i = 1; i < 100; i++) strobe(sine[i % 16], we, a, ws, fd);
        checks++;
        if (we !== 1'b1 || a !== 9'h100 + 9'd99) begin
            errors++;
            $display("FAIL write_99: we=%b addr=%h, expected we=1 addr=163", we, a);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (write_enable !== 1'b0 || write_address !== 9'h000 || write_sample !== 8'h00
            || frame_done !== 1'b0 || read_index !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: we=%b addr=%h ws=%h fd=%b ri=%b, expected all 0",
                     write_enable, write_address, write_sample, frame_done, read_index);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        strobe(16'h0100, we, a, ws, fd);
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL first_after_reset: we=%b, expected 0", we);
        end
        strobe(16'h8000, we, a, ws, fd);
        strobe(16'h0100, we, a, ws, fd);
        checks++;
        if (we !== 1'b1 || a !== 9'h100 || ws !== 8'h81) begin
            errors++;
            $display("FAIL restart_write: we=%b addr=%h ws=%h, expected we=1 addr=100 ws=81", we, a, ws);
        end
    endtask

    task automatic test_timeout();
        logic we, fd;
        logic [8:0] a;
        logic [7:0] ws;
        do_reset();
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        for (int i = 1; i <= 10; i++) begin
            strobe(16'h1234, we, a, ws, fd);
            checks++;
            if (i < 10 && we !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early%0d: we=%b, expected 0", i, we);
            end else if (i == 10 && (we !== 1'b1 || a !== 9'h100 || ws !== 8'h92)) begin
                errors++;
                $display("FAIL timeout_write: we=%b addr=%h ws=%h, expected we=1 addr=100 ws=92", we, a, ws);
            end
        end
`else
        for (int i = 1; i <= 30; i++) begin
            strobe(16'h1234, we, a, ws, fd);
            checks++;
            if (we !== 1'b0) begin
                errors++;
                $display("FAIL dc_no_write%0d: we=%b, expected 0", i, we);
            end
        end
`endif
    endtask

    initial begin
        reset_n           = 1'b0;
        new_sample_ready  = 1'b0;
        new_sample_in     = 16'h0000;
        wave_display_idle = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_trigger();
        test_back_to_back();
        test_wait_hold();
        test_wait_exit_strobe();
        test_zero_crossing();
        test_reset_mid_frame();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
